// File: rtl/fft_agu.sv
// rtl/fft_agu.sv - radix-2 in-place FFT address generator and level sequencer
// Issues read/twiddle addresses per butterfly and the matching write one cycle later.
module fft_agu #(
    parameter int log2n = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic             rd_bank,
    output logic [log2n-1:0] rd_adr_a,
    output logic [log2n-1:0] rd_adr_b,
    output logic [log2n-2:0] tw_adr,
    output logic             we,
    output logic             wr_bank,
    output logic [log2n-1:0] wr_adr_a,
    output logic [log2n-1:0] wr_adr_b
);

    localparam int iw = log2n - 1;
    localparam int lw = $clog2(log2n);
    localparam logic [iw-1:0] idx_last   = '1;
    localparam logic [iw-1:0] all_ones   = '1;
    localparam logic [lw-1:0] level_last = lw'(log2n - 1);

    typedef enum logic [1:0] {
        s_idle,
        s_run,
        s_drain,
        s_done
    } state_t;

    state_t          state;
    logic [lw-1:0]   level;
    logic [iw-1:0]   idx;

    logic [log2n-1:0]   pair_a;
    logic [log2n-1:0]   pair_b;
    logic [2*log2n-1:0] dbl_a;
    logic [2*log2n-1:0] dbl_b;
    logic [iw-1:0]      tw_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= s_idle;
            level <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
        end else begin
            case (state)
                s_idle, s_done: begin
                    if (start) begin
                        state <= s_run;
                        level <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        rd_en <= 1'b1;
                    end
                end
                s_run: begin
                    if (idx == idx_last) begin
                        state <= s_drain;
                        rd_en <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                s_drain: begin
                    // One idle read slot lets the level's last write land before the next level reads.
                    if (level == level_last) begin
                        state <= s_done;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= s_run;
                        level <= level + 1'b1;
                        idx   <= '0;
                        rd_en <= 1'b1;
                    end
                end
                default: begin
                    state <= s_idle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Butterfly pair (2*idx, 2*idx+1) rotated left by level selects the in-place stride.
    assign pair_a  = {idx, 1'b0};
    assign pair_b  = {idx, 1'b1};
    assign dbl_a   = {pair_a, pair_a} << level;
    assign dbl_b   = {pair_b, pair_b} << level;
    assign tw_mask = ~(all_ones >> level);

    assign rd_bank  = rd_en & level[0];
    assign rd_adr_a = rd_en ? dbl_a[2*log2n-1:log2n] : '0;
    assign rd_adr_b = rd_en ? dbl_b[2*log2n-1:log2n] : '0;
    assign tw_adr   = rd_en ? (idx & tw_mask) : '0;

    // Write stage trails the read by the one-cycle RAM latency and targets the other bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            we       <= 1'b0;
            wr_bank  <= 1'b0;
            wr_adr_a <= '0;
            wr_adr_b <= '0;
        end else begin
            we       <= rd_en;
            wr_bank  <= rd_en & ~rd_bank;
            wr_adr_a <= rd_adr_a;
            wr_adr_b <= rd_adr_b;
        end
    end

endmodule

// File: tb/tb_fft_agu.sv
// tb/tb_fft_agu.sv - scoreboard bench for fft_agu with N=32
module tb_fft_agu;

    localparam int LOG2N = 5;
    localparam int H     = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, rd_en, rd_bank, we, wr_bank;
    logic [4:0] rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
    logic [3:0] tw_adr;

    fft_agu #(.log2n(LOG2N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_bank(rd_bank),
        .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b), .tw_adr(tw_adr),
        .we(we), .wr_bank(wr_bank),
        .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic [3:0] tw;
        logic       bank;
    } rd_t;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic       bank;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    rd_t mon_rd;
    wr_t mon_wr;

    int checks = 0;
    int failures = 0;
    int wr_seen = 0;
    int dup = 0;
    logic [31:0] wmask [LOG2N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rotl_m(input int x, input int l);
        int r = 0;
        for (int i = 0; i < LOG2N; i++)
            if (((x >> i) & 1) != 0) r |= 1 << ((i + l) % LOG2N);
        return r;
    endfunction

    task automatic push_run();
        rd_t r;
        wr_t w;
        for (int l = 0; l < LOG2N; l++) begin
            for (int i = 0; i < H; i++) begin
                r.a    = 5'(rotl_m(2 * i, l));
                r.b    = 5'(rotl_m(2 * i + 1, l));
                r.tw   = 4'(i & ((15 << (4 - l)) & 15));
                r.bank = 1'(l & 1);
                w.a    = r.a;
                w.b    = r.b;
                w.bank = ~r.bank;
                rd_q.push_back(r);
                wr_q.push_back(w);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read or a write.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    mon_rd = rd_q.pop_front();
                    chk("rd_adr_a", rd_adr_a, mon_rd.a);
                    chk("rd_adr_b", rd_adr_b, mon_rd.b);
                    chk("tw_adr", tw_adr, mon_rd.tw);
                    chk("rd_bank", rd_bank, mon_rd.bank);
                end
            end
            if (we) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mon_wr = wr_q.pop_front();
                    chk("wr_adr_a", wr_adr_a, mon_wr.a);
                    chk("wr_adr_b", wr_adr_b, mon_wr.b);
                    chk("wr_bank", wr_bank, mon_wr.bank);
                end
                if (wr_seen < LOG2N * H) begin
                    if (wmask[wr_seen / H][wr_adr_a]) dup++;
                    wmask[wr_seen / H][wr_adr_a] = 1'b1;
                    if (wmask[wr_seen / H][wr_adr_b]) dup++;
                    wmask[wr_seen / H][wr_adr_b] = 1'b1;
                end
                wr_seen++;
            end
        end
    end

    task automatic run_check(input bit disturb);
        int wes, busy_n, done_cyc;
        rd_q.delete();
        wr_q.delete();
        wr_seen = 0;
        dup = 0;
        for (int l = 0; l < LOG2N; l++) wmask[l] = '0;
        push_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wes = 0;
        busy_n = 0;
        done_cyc = 0;
        for (int k = 1; k <= 90; k++) begin
            if (k > 1) @(negedge clk);
            start = disturb && (k == 10 || k == 40);
            if (we) wes++;
            if (busy) busy_n++;
            if (done && done_cyc == 0) begin
                done_cyc = k;
                chk("busy_at_done", busy, 0);
            end
            case (k)
                1: begin
                    chk("c1_rd_en", rd_en, 1);
                    chk("c1_rd_a", rd_adr_a, 0);
                    chk("c1_rd_b", rd_adr_b, 1);
                    chk("c1_tw", tw_adr, 0);
                    chk("c1_bank", rd_bank, 0);
                    chk("c1_busy", busy, 1);
                    chk("c1_we", we, 0);
                end
                2: begin
                    chk("c2_we", we, 1);
                    chk("c2_wr_a", wr_adr_a, 0);
                    chk("c2_wr_b", wr_adr_b, 1);
                    chk("c2_wr_bank", wr_bank, 1);
                end
                16: begin
                    chk("c16_rd_a", rd_adr_a, 30);
                    chk("c16_rd_b", rd_adr_b, 31);
                end
                17: begin
                    chk("c17_rd_en", rd_en, 0);
                    chk("c17_we", we, 1);
                end
                40: begin
                    chk("l2i5_rd_a", rd_adr_a, 9);
                    chk("l2i5_rd_b", rd_adr_b, 13);
                    chk("l2i5_tw", tw_adr, 4);
                    chk("l2i5_bank", rd_bank, 0);
                end
                84: begin
                    chk("l4i15_rd_a", rd_adr_a, 15);
                    chk("l4i15_rd_b", rd_adr_b, 31);
                    chk("l4i15_tw", tw_adr, 15);
                    chk("l4i15_bank", rd_bank, 0);
                end
                default: ;
            endcase
            if (k == 18 || k == 35 || k == 52 || k == 69 || k == 86)
                chk("we_after_drain", we, 0);
        end
        start = 1'b0;
        chk("we_pulses", wes, 80);
        chk("done_cycle", done_cyc, 86);
        chk("busy_span", busy_n, 85);
        chk("rd_left", rd_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        chk("dup_writes", dup, 0);
        for (int l = 0; l < LOG2N; l++) chk("level_coverage", $countones(wmask[l]), 32);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_we", we, 0);
            chk("rst_banks", {rd_bank, wr_bank}, 0);
            chk("rst_rd_adr", {rd_adr_a, rd_adr_b, tw_adr}, 0);
            chk("rst_wr_adr", {wr_adr_a, wr_adr_b}, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_wr_bank", wr_bank, 0);

        run_check(1'b0);
        run_check(1'b1);

        // Reset in cycle 30 of a fresh run.
        rd_q.delete();
        wr_q.delete();
        push_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_we", we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_done", done, 0);
        reset = 1'b0;
        rd_q.delete();
        wr_q.delete();

        run_check(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
